decode_id_ex: RTL
=================

# decode_id_ex

Decode stage with integrated ID/EX pipeline register for the LEGv8 datapath. It accepts a fetched instruction and its PC, reads two operands from a 32 x N register file, and sign-extends the immediate. The result is registered into the operand bundle that the execute stage consumes (PC_E, signImm_E, readData1_E, readData2_E). It also owns the register-file write port driven from writeback, and supports stall and flush.

## Interface
Parameters:
- N, 64, datapath and register width

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- instr_D  in  32  instruction from fetch
- PC_D  in  N  PC of instr_D
- valid_D  in  1  instr_D/PC_D are valid this cycle
- stall  in  1  hold ID/EX contents
- flush  in  1  squash ID/EX contents (bubble)
- regWrite_W  in  1  writeback enable
- writeReg_W  in  5  writeback destination
- writeData_W  in  N  writeback data
- PC_E  out  N  registered PC
- signImm_E  out  N  registered sign-extended immediate
- readData1_E  out  N  registered Rn operand
- readData2_E  out  N  registered second operand (Rm or Rt)
- writeReg_E  out  5  registered destination Rt/Rd (instr[4:0])
- valid_E  out  1  ID/EX bundle is valid

## Operation
- Register file: 32 entries x N. Reads of X31 return 0. Writes to X31 are ignored.
  - Write on rising clk when regWrite_W=1.
  - Read port 1 address = instr_D[9:5] (Rn).
  - Read port 2 address = instr_D[4:0] (Rt) for STUR and CBZ, else instr_D[20:16] (Rm).
- Write-through bypass: a same-cycle write to a nonzero address that matches a read address returns writeData_W on that read.
- Immediate extraction, sign-extended to N unless noted:
  - LDUR/STUR (instr[31:21] = 11'h7C2 / 11'h7C0): instr[20:12].
  - CBZ (instr[31:24] = 8'hB4): instr[23:5].
  - B (instr[31:26] = 6'b000101): instr[25:0].
  - ADDI (instr[31:22] = 10'h244): instr[21:10], zero-extended.
  - Any other encoding: 0.
- ID/EX update priority per cycle:
  1. flush=1: valid_E<=0 and all data outputs <=0, regardless of stall.
  2. stall=1: all outputs hold.
  3. Otherwise: outputs load the decoded values and valid_E<=valid_D.
- With valid_D=0 and no stall or flush, the data outputs still load (don't-care), but valid_E<=0.
- Register-file writes are never blocked by stall or flush.
- Values held during a stall are not refreshed by writeback. Hazard resolution belongs to the hazard unit upstream.

## Timing
- Latency: instruction presented in cycle t appears on the _E outputs after rising edge t+1.
- Throughput: one instruction per cycle when stall=0.
- Reset (reset_n=0, asynchronous): all outputs 0, valid_E=0, all 32 register-file entries cleared to 0. Takes effect immediately, mid-operation included.
- First update after reset: the first rising edge with reset_n=1.
- Write then read of the same register: the write at edge t is visible to an instruction decoded in cycle t via bypass, and therefore latched at edge t+1.
- Simultaneous flush+stall: flush wins.
- Writes to X31 are ignored even when bypass addresses match.

## Structure
- Shared package legv8_pkg:
  - opcode constants OP_LDUR, OP_STUR, OP_CBZ, OP_B, OP_ADDI, each with its field width;
  - register index constant XZR=5'd31.
- Sub-module regfile #(N): 2 read ports, 1 write port, async reset, X31 hardwired to zero, write-through bypass.
- Sign extension is combinational inside decode_id_ex, ahead of the ID/EX register.

## Test plan
- Reset: assert reset_n=0 mid-stream -> all outputs 0 and valid_E=0 immediately; reads of X1..X30 return 0 after release.
- Writeback then ADD: write X1=64'h5, X2=64'h7; decode ADD X3,X1,X2 -> next cycle readData1_E=5, readData2_E=7, writeReg_E=3, valid_E=1.
- Bypass and X31:
  - regWrite_W to X4=64'hA in the same cycle as decoding a read of X4 -> readData1_E=64'hA;
  - write X31=64'hFF then read X31 -> 0.
- Immediates:
  - LDUR imm9=9'h1F0 -> signImm_E=64'hFFFF_FFFF_FFFF_FFF0;
  - CBZ imm19=19'h7FFFF -> signImm_E=-1;
  - ADDI imm12=12'hFFF -> signImm_E=64'hFFF;
  - STUR reads Rt on port 2.
- Stall/flush:
  - stall for 3 cycles while instr_D changes -> outputs hold;
  - stall=1 with flush=1 -> valid_E=0 and outputs 0;
  - release -> the next instruction loads after one edge.

Source files
------------

// File: rtl/legv8_pkg.sv
// Shared LEGv8 decode constants: opcode patterns sized to the bits each one
// matches, plus the hardwired-zero register index.
package legv8_pkg;

  localparam logic [10:0] OP_LDUR = 11'h7C2;    // instr[31:21]
  localparam logic [10:0] OP_STUR = 11'h7C0;    // instr[31:21]
  localparam logic [7:0]  OP_CBZ  = 8'hB4;      // instr[31:24]
  localparam logic [5:0]  OP_B    = 6'b000101;  // instr[31:26]
  localparam logic [9:0]  OP_ADDI = 10'h244;    // instr[31:22]

  localparam logic [4:0]  XZR     = 5'd31;

  // Immediate formats recognised by the decoder.
  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_D,     // LDUR/STUR 9-bit signed offset
    IMM_CB,    // CBZ 19-bit signed offset
    IMM_B,     // B 26-bit signed offset
    IMM_I      // ADDI 12-bit unsigned immediate
  } imm_kind_e;

endpackage

// File: rtl/regfile.sv
// 32 x N register file: two combinational read ports, one write port,
// X31 reads as zero and ignores writes, same-cycle writes bypass to reads.
module regfile
  import legv8_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [4:0]   ra1,
  input  logic [4:0]   ra2,
  input  logic         we,
  input  logic [4:0]   wa,
  input  logic [N-1:0] wd,
  output logic [N-1:0] rd1,
  output logic [N-1:0] rd2
);

  logic [N-1:0] mem [32];

  // Storage: cleared on reset, written from writeback; X31 is never written.
  // NOTE: the array is reset because every register must read as zero after reset; this forces flops rather than a RAM macro.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (we && wa != XZR) begin
      mem[wa] <= wd;
    end
  end

  // Read port 1 with zero register and write-through bypass.
  always_comb begin
    if (ra1 == XZR)                  rd1 = '0;
    else if (we && wa == ra1)        rd1 = wd;
    else                             rd1 = mem[ra1];
  end

  // Read port 2, same rules as port 1.
  always_comb begin
    if (ra2 == XZR)                  rd2 = '0;
    else if (we && wa == ra2)        rd2 = wd;
    else                             rd2 = mem[ra2];
  end

endmodule

// File: rtl/decode_id_ex.sv
// LEGv8 decode stage: register read, immediate sign extension and the
// ID/EX pipeline register with stall/flush.
module decode_id_ex
  import legv8_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [31:0]  instr_D,
  input  logic [N-1:0] PC_D,
  input  logic         valid_D,
  input  logic         stall,
  input  logic         flush,
  input  logic         regWrite_W,
  input  logic [4:0]   writeReg_W,
  input  logic [N-1:0] writeData_W,
  output logic [N-1:0] PC_E,
  output logic [N-1:0] signImm_E,
  output logic [N-1:0] readData1_E,
  output logic [N-1:0] readData2_E,
  output logic [4:0]   writeReg_E,
  output logic         valid_E
);

  imm_kind_e    imm_kind;
  logic         use_rt;
  logic [4:0]   ra2;
  logic [N-1:0] imm_ext;
  logic [N-1:0] rd1;
  logic [N-1:0] rd2;

  // Classify the instruction: immediate format and second read source.
  // NOTE: every output gets a default first so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    imm_kind = IMM_NONE;
    use_rt   = 1'b0;
    if (instr_D[31:21] == OP_LDUR) begin
      imm_kind = IMM_D;
    end else if (instr_D[31:21] == OP_STUR) begin
      imm_kind = IMM_D;
      use_rt   = 1'b1;
    end else if (instr_D[31:24] == OP_CBZ) begin
      imm_kind = IMM_CB;
      use_rt   = 1'b1;
    end else if (instr_D[31:26] == OP_B) begin
      imm_kind = IMM_B;
    end else if (instr_D[31:22] == OP_ADDI) begin
      imm_kind = IMM_I;
    end
  end

  assign ra2 = use_rt ? instr_D[4:0] : instr_D[20:16];

  // Extract and extend the immediate for the selected format.
  always_comb begin
    imm_ext = '0;
    unique case (imm_kind)
      IMM_D:   imm_ext = {{(N-9){instr_D[20]}},  instr_D[20:12]};
      IMM_CB:  imm_ext = {{(N-19){instr_D[23]}}, instr_D[23:5]};
      IMM_B:   imm_ext = {{(N-26){instr_D[25]}}, instr_D[25:0]};
      IMM_I:   imm_ext = {{(N-12){1'b0}},        instr_D[21:10]};
      default: imm_ext = '0;
    endcase
  end

  regfile #(.N(N)) u_regfile (
    .clk     (clk),
    .reset_n (reset_n),
    .ra1     (instr_D[9:5]),
    .ra2     (ra2),
    .we      (regWrite_W),
    .wa      (writeReg_W),
    .wd      (writeData_W),
    .rd1     (rd1),
    .rd2     (rd2)
  );

  // ID/EX register: flush beats stall, stall holds, otherwise load.
  // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      PC_E        <= '0;
      signImm_E   <= '0;
      readData1_E <= '0;
      readData2_E <= '0;
      writeReg_E  <= '0;
      valid_E     <= 1'b0;
    end else if (flush) begin
      PC_E        <= '0;
      signImm_E   <= '0;
      readData1_E <= '0;
      readData2_E <= '0;
      writeReg_E  <= '0;
      valid_E     <= 1'b0;
    end else if (!stall) begin
      PC_E        <= PC_D;
      signImm_E   <= imm_ext;
      readData1_E <= rd1;
      readData2_E <= rd2;
      writeReg_E  <= instr_D[4:0];
      valid_E     <= valid_D;
    end
  end

endmodule
